// File: rtl/pc_target_unit_pkg.sv
// Shared encodings for the next-PC unit: PC source select, FSM states and trap causes.
package pc_target_unit_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ  = 2'b00,
        PCSRC_BR   = 2'b01,
        PCSRC_JALR = 2'b10,
        PCSRC_RSV  = 2'b11
    } pcsrc_e;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_TRAP   = 1'b1
    } state_e;

    localparam logic CAUSE_BR   = 1'b0;
    localparam logic CAUSE_JALR = 1'b1;

    // Only control-flow targets are alignment-checked; the reserved encoding never traps.
    function automatic logic src_can_trap(input pcsrc_e src);
        return (src == PCSRC_BR) || (src == PCSRC_JALR);
    endfunction

endpackage

// File: rtl/pc_target_unit_if.sv
// Bundle between the control/immediate side (master) and the next-PC unit (slave).
interface pc_target_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);
    logic             Stall;
    logic [1:0]       PCSrc;
    logic [XLEN-1:0]  ImmExt;
    logic [XLEN-1:0]  RS1;
    logic [XLEN-1:0]  PC;
    logic [XLEN-1:0]  PCPlusStep;
    logic [XLEN-1:0]  PCTarget;
    logic             TrapValid;
    logic [XLEN-1:0]  TrapAddr;
    logic             TrapCause;
    logic [CNT_W-1:0] RetireCount;

    modport master (
        output Stall, PCSrc, ImmExt, RS1,
        input  PC, PCPlusStep, PCTarget, TrapValid, TrapAddr, TrapCause, RetireCount
    );

    modport slave (
        input  Stall, PCSrc, ImmExt, RS1,
        output PC, PCPlusStep, PCTarget, TrapValid, TrapAddr, TrapCause, RetireCount
    );
endinterface

// File: rtl/pc_target_unit_pc_adder.sv
// Plain XLEN-bit adder; carry-out is dropped so sums wrap modulo 2^XLEN.
module pc_adder #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] sum
);
    assign sum = a + b;
endmodule

// File: rtl/pc_target_unit.sv
// Architectural PC register with sequential/branch/JALR target selection,
// misaligned-target trap redirection and a retired-instruction counter.
module pc_target_unit
    import pc_target_unit_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              INSTR_BYTES  = 4,
    parameter int              ALIGN_BITS   = 2,
    parameter int              CNT_W        = 64
) (
    input  logic            clk,
    input  logic            reset,
    pc_target_unit_if.slave bus
);

    localparam int N_ADD    = 3;
    localparam int ADD_STEP = 0;
    localparam int ADD_BR   = 1;
    localparam int ADD_JALR = 2;

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    state_e           state_reg, state_next;
    logic [XLEN-1:0]  pc_reg, pc_next;
    logic [XLEN-1:0]  trap_addr_reg, trap_addr_next;
    logic             trap_cause_reg, trap_cause_next;
    logic [CNT_W-1:0] retire_reg, retire_next;

    logic [XLEN-1:0]  add_a   [N_ADD];
    logic [XLEN-1:0]  add_b   [N_ADD];
    logic [XLEN-1:0]  add_sum [N_ADD];

    logic [XLEN-1:0]  pc_plus_step;
    logic [XLEN-1:0]  pc_target;
    logic [XLEN-1:0]  jalr_target;
    logic [XLEN-1:0]  sel_target;
    pcsrc_e           src;
    logic             misaligned;

    assign add_a[ADD_STEP] = pc_reg;
    assign add_b[ADD_STEP] = XLEN'(INSTR_BYTES);
    assign add_a[ADD_BR]   = pc_reg;
    assign add_b[ADD_BR]   = bus.ImmExt;
    assign add_a[ADD_JALR] = bus.RS1;
    assign add_b[ADD_JALR] = bus.ImmExt;

    genvar gi;
    generate
        for (gi = 0; gi < N_ADD; gi++) begin : g_add
            pc_adder #(.XLEN(XLEN)) u_add (
                .a   (add_a[gi]),
                .b   (add_b[gi]),
                .sum (add_sum[gi])
            );
        end
    endgenerate

    assign pc_plus_step = add_sum[ADD_STEP];
    assign pc_target    = add_sum[ADD_BR];
    assign jalr_target  = {add_sum[ADD_JALR][XLEN-1:1], 1'b0};
    assign src          = pcsrc_e'(bus.PCSrc);

    always_comb begin
        sel_target = pc_plus_step;
        case (src)
            PCSRC_BR:   sel_target = pc_target;
            PCSRC_JALR: sel_target = jalr_target;
            default:    sel_target = pc_plus_step;
        endcase
        misaligned = src_can_trap(src) && ((sel_target & ALIGN_MASK) != '0);
    end

    // TRAP only flags the pulse; inputs seen during it are processed like NORMAL,
    // so a stall or a fresh misaligned target there behaves as it would anywhere.
    always_comb begin
        state_next      = ST_NORMAL;
        pc_next         = pc_reg;
        trap_addr_next  = trap_addr_reg;
        trap_cause_next = trap_cause_reg;
        retire_next     = retire_reg;
        if (!bus.Stall) begin
            if (misaligned) begin
                state_next      = ST_TRAP;
                pc_next         = TRAP_VECTOR;
                trap_addr_next  = sel_target;
                trap_cause_next = (src == PCSRC_JALR) ? CAUSE_JALR : CAUSE_BR;
            end else begin
                pc_next     = sel_target;
                retire_next = retire_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_NORMAL;
            pc_reg         <= RESET_VECTOR;
            trap_addr_reg  <= '0;
            trap_cause_reg <= CAUSE_BR;
            retire_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            trap_addr_reg  <= trap_addr_next;
            trap_cause_reg <= trap_cause_next;
            retire_reg     <= retire_next;
        end
    end

    assign bus.PC          = pc_reg;
    assign bus.PCPlusStep  = pc_plus_step;
    assign bus.PCTarget    = pc_target;
    assign bus.TrapValid   = (state_reg == ST_TRAP);
    assign bus.TrapAddr    = trap_addr_reg;
    assign bus.TrapCause   = trap_cause_reg;
    assign bus.RetireCount = retire_reg;

endmodule
